mem_burst_initiator: RTL and testbench

Initiator side of the 8×8 dual-port `memory` write/read interface. It accepts a burst command and streams words in or out over valid/ready handshakes. It also drives the memory's `write`/`read`/`addr_w`/`addr_r`/`datain` ports and collects `dataout`. It sits between a data producer/consumer and one `memory` instance, so upstream logic never sequences addresses itself.

---
 rtl/mem_pkg.sv | 16 +
 rtl/rd_skid_fifo.sv | 74 +++++++
 rtl/mem_burst_initiator.sv | 144 ++++++++++++++
 tb/tb_mem_burst_initiator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst initiator.
//   MEM_DATA_W / MEM_ADDR_W : default word and address widths of the 8x8 memory
//   RD_FIFO_DEPTH           : read-return buffer depth (covers the 2-cycle credit loop)
//   mem_burst_state_t       : burst FSM states
package mem_pkg;
  localparam int MEM_DATA_W    = 8;
  localparam int MEM_ADDR_W    = 3;
  localparam int RD_FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } mem_burst_state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// Small circular FIFO that buffers memory read data ahead of the out_* stream.
//   clock, reset_n      : clock, async active-low reset
//   push, push_data     : enqueue (ignored when full and not popping)
//   pop                 : dequeue (ignored when empty)
//   head_data           : oldest entry
//   count, empty, full  : occupancy status
module rd_skid_fifo
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = RD_FIFO_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [DATA_W-1:0]              head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator for an 8x8 dual-port memory. Takes a (dir, base_addr, len)
// command and streams len+1 words between a valid/ready stream and the memory,
// sequencing addresses with modulo wrap.
//   clock, reset_n                     : clock, async active-low reset
//   start, dir, base_addr, len         : command (sampled in IDLE only)
//   busy, done                         : status; done is a one-cycle pulse
//   in_valid, in_data, in_ready        : write-data stream
//   out_valid, out_data, out_ready     : read-data stream
//   mem_write, mem_addr_w, mem_datain  : memory write port
//   mem_read, mem_addr_r, mem_dataout  : memory read port (data one cycle after read)
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [DATA_W-1:0] mem_dataout
);
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH+1);
  typedef logic [CNT_W:0] occ_t;

  mem_burst_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic              inflight_q, inflight_d, done_q, done_d;

  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full, pop;
  occ_t              occupancy;

  rd_skid_fifo #(.DATA_W(DATA_W), .DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (mem_dataout),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Credits: every word either buffered or still returning from memory
  // holds a FIFO slot, so an issue can never overflow the buffer.
  assign occupancy = occ_t'(fifo_count) + occ_t'(inflight_q);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    mem_write  = 1'b0;
    mem_addr_w = '0;
    mem_datain = '0;
    mem_read   = 1'b0;
    mem_addr_r = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = len;
          state_d = dir ? WRITE : READ;
        end
      end
      WRITE: begin
        in_ready   = 1'b1;
        mem_write  = in_valid;
        mem_addr_w = addr_q;
        mem_datain = in_data;
        if (in_valid) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        mem_addr_r = addr_q;
        if (!fifo_full && occupancy < occ_t'(RD_FIFO_DEPTH)) begin
          mem_read = 1'b1;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the pop that empties the buffer so busy falls with done.
        if (!inflight_q && pop && fifo_count == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!inflight_q && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inflight_d = mem_read;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard bench for mem_burst_initiator with a behavioral 8x8 memory.
module tb_mem_burst_initiator;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, dir = 1'b0;
  logic [AW-1:0] base_addr = '0, len = '0;
  logic          busy, done;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_addr_w, mem_addr_r;
  logic [DW-1:0] mem_datain, mem_dataout;

  always #5 clock = ~clock;

  mem_burst_initiator #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dir(dir),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_write(mem_write), .mem_addr_w(mem_addr_w), .mem_datain(mem_datain),
    .mem_read(mem_read), .mem_addr_r(mem_addr_r), .mem_dataout(mem_dataout)
  );

  // Behavioral memory: synchronous write, registered read.
  logic [DW-1:0] mem_arr [8];
  always @(posedge clock) begin
    if (mem_write) mem_arr[mem_addr_w] <= mem_datain;
    if (mem_read)  mem_dataout <= mem_arr[mem_addr_r];
  end

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0]    ref_mem [8];
  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    rd_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [27:0] out_vec();
    return {busy, done, in_ready, out_valid, mem_write, mem_read,
            out_data, mem_addr_w, mem_addr_r, mem_datain};
  endfunction

  // Monitor: pops the scoreboard on every memory write and every accepted
  // read word; also tracks outstanding reads and stall stability.
  int               issued = 0, accepted = 0;
  logic             stall_q = 1'b0;
  logic [DW-1:0]    stall_data = '0;
  logic [AW+DW-1:0] e;
  always @(negedge clock) begin
    if (!reset_n) begin
      issued = 0; accepted = 0; stall_q = 1'b0;
    end else begin
      if (mem_write) begin
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", mem_addr_w, e[DW +: AW]);
          check("wr_data", mem_datain, e[DW-1:0]);
        end
      end
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, stall_data);
      end
      if (mem_read) begin
        check("outstanding_le3", (issued - accepted) < 3, 1);
        issued++;
      end
      if (out_valid && out_ready) begin
        accepted++;
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_data", out_data, rd_q.pop_front());
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic do_write(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [DW-1:0] d0, input logic [DW-1:0] step,
                          input bit gap, input bit poke);
    int nw, k, cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    nw = int'(l) + 1; k = 0; cyc = 0;
    for (int i = 0; i < nw; i++) begin
      a = b + AW'(i);
      wd = d0 + DW'(i) * step;
      wr_q.push_back({a, wd});
      ref_mem[a] = wd;
    end
    @(posedge clock); #1;
    start = 1'b1; dir = 1'b1; base_addr = b; len = l;
    @(posedge clock); #1;
    start = 1'b0; dir = 1'b0;
    while (k < nw && cyc < 50) begin
      if (gap && (cyc % 2 == 1)) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_data = d0 + DW'(k) * step; end
      if (poke && cyc == 1) begin start = 1'b1; dir = 1'b0; base_addr = '0; len = 3'd7; end
      else start = 1'b0;
      @(negedge clock);
      if (cyc == 0) begin
        check("wr_busy", busy, 1);
        check("wr_in_ready", in_ready, 1);
      end
      if (in_valid && in_ready) k++;
      cyc++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; start = 1'b0;
    if (k < nw) check("wr_timeout", k, nw);
    @(negedge clock);
    check("wr_done", done, 1);
    check("wr_done_busy", busy, 0);
    @(negedge clock);
    check("wr_done_pulse", done, 0);
    check("wr_sb_empty", wr_q.size(), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit bp);
    int nw, cyc;
    bit got_done;
    logic [3:0] pat;
    pat = 4'b1001;
    nw = int'(l) + 1; cyc = 0; got_done = 1'b0;
    for (int i = 0; i < nw; i++) rd_q.push_back(ref_mem[b + AW'(i)]);
    @(posedge clock); #1;
    start = 1'b1; dir = 1'b0; base_addr = b; len = l;
    @(posedge clock); #1;
    start = 1'b0;
    while (!got_done && cyc < 200) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      @(negedge clock);
      if (cyc == 0) begin
        check("rd_busy", busy, 1);
        check("rd_issue_lat", mem_read, 1);
      end
      if (!bp && cyc == 1) check("rd_no_early_valid", out_valid, 0);
      if (!bp && cyc >= 2 && cyc < nw + 2) check("rd_stream_valid", out_valid, 1);
      if (done) begin
        got_done = 1'b1;
        check("rd_done_busy", busy, 0);
        check("rd_done_cycle_ok", bp || (cyc == nw + 2), 1);
      end
      cyc++;
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    if (!got_done) check("rd_timeout", 0, 1);
    check("rd_sb_empty", rd_q.size(), 0);
    @(negedge clock);
    check("rd_done_pulse", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_outputs", out_vec(), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    do_write(3'd0, 3'd7, 8'h11, 8'h11, 1'b0, 1'b0);  // fill all 8 words
    do_write(3'd5, 3'd3, 8'h05, 8'h01, 1'b0, 1'b0);  // 5,6,7,0
    do_read (3'd5, 3'd3, 1'b0);
    do_read (3'd0, 3'd7, 1'b1);                      // 1-0-0-1 backpressure
    do_write(3'd3, 3'd1, 8'h40, 8'h30, 1'b1, 1'b0);  // gapped: 0x40@3, 0x70@4
    do_write(3'd2, 3'd2, 8'hC0, 8'h01, 1'b0, 1'b1);  // stray start mid-burst
    do_read (3'd6, 3'd3, 1'b0);                      // wraps 6,7,0,1

    // Abort a read with words buffered.
    for (int i = 0; i < 8; i++) rd_q.push_back(ref_mem[i]);
    @(posedge clock); #1;
    start = 1'b1; dir = 1'b0; base_addr = 3'd0; len = 3'd7; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("pre_reset_buffered", out_valid, 1);
    #1 reset_n = 1'b0;
    #1 check("reset_abort_outputs", out_vec(), 0);
    rd_q.delete();
    @(negedge clock);
    check("reset_no_done", done, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_idle", out_vec(), 0);

    do_read(3'd0, 3'd7, 1'b1);
    do_read(3'd3, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
